audio_alu_pipe: RTL and testbench
=================================

// Module: audio_alu_pipe
// PURPOSE
//  Parametrised, pipelined successor of the 16-bit datapath ALU for the audio core.
//  Signed two's-complement (Q-format) operands; valid/ready in and out; internal MAC accumulator.
//  Sits between the operand-fetch stage and the filter/effects writeback stage.
// PARAMETERS
//  WIDTH    16  operand/result width (bits), >=8
//  FRAC     15  fractional bits; MUL/MAC products arithmetic-shifted right by FRAC
//  ACC_W    40  accumulator width, >= 2*WIDTH-FRAC+1
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      operands/op valid
//  in_ready   out  1      block can accept this cycle
//  a          in   WIDTH  operand A (signed)
//  b          in   WIDTH  operand B (signed)
//  sel        in   4      opcode (see BEHAVIOUR)
//  acc_clr    in   1      clear accumulator; qualified by in_valid&in_ready
//  out_valid  out  1      result valid
//  out_ready  in   1      downstream accepts
//  result     out  WIDTH  result
//  zflag      out  1      result == 0
//  err        out  1      opcode was illegal (result forced 0)
// BEHAVIOUR
//  Opcodes: 0000 ADD, 0001 SUB, 0010 MUL, 0101 MAC, 0111 AND, 1000 OR, 1001 XOR,
//   1010 XNOR, 1100 EQ (result 1/0), 1101 NOP (result 0, err=0). All others: err=1, result 0.
//  Pipeline: S1 registers operands/op (product computed), S2 registers result/flags. Latency 2.
//  Handshake: transfer on valid&ready each side. in_ready = ~s1_v | ~s2_v | out_ready; whole pipe
//   stalls when S2 full and ~out_ready; no bubble insertion, no drop, no duplication.
//  out_valid/result/zflag/err stable while out_valid & ~out_ready.
//  MUL: full 2*WIDTH product >>> FRAC, then narrowed to WIDTH (see CONFIGURATION).
//  MAC: acc <= acc + (a*b >>> FRAC), sign-extended to ACC_W; result = acc narrowed to WIDTH.
//   acc updates once per accepted MAC, in the S1->S2 transfer cycle; acc wraps at ACC_W.
//  acc_clr with non-MAC op: acc <= 0. acc_clr with MAC: acc <= product (clear then accumulate).
//  acc_clr without in_valid&in_ready: ignored.
//  ADD/SUB computed at WIDTH+1, then narrowed. EQ/logic ops never saturate.
//  Reset (mid-operation too): s1_v=s2_v=0, out_valid=0, result=0, zflag=1, err=0, acc=0;
//   in-flight ops lost; in_ready=1 from the first cycle after deassertion.
// CONFIGURATION
//  `ALU_SAT_EN defined: ADD/SUB/MUL/MAC outputs clamp to [-2^(WIDTH-1), 2^(WIDTH-1)-1];
//   accumulator itself still wraps at ACC_W (only the output view is clamped).
//  Undefined: outputs take the low WIDTH bits (two's-complement wrap).
// STRUCTURE
//  Package audio_alu_pkg: opcode localparams (OP_ADD..OP_NOP), opcode enum typedef,
//   function is_legal_op(sel).
//  One sub-module: audio_alu_sat (combinational narrow-with-optional-clamp, IN_W->WIDTH),
//   instantiated for arith result and MAC output.
// TESTING  (WIDTH=16, FRAC=15, ACC_W=40)
//  ADD 0x7FFF+0x0001 -> SAT_EN: 0x7FFF; no SAT_EN: 0x8000; zflag=0; out_valid 2 cycles after accept.
//  MUL 0x4000*0x4000 (0.5*0.5) -> 0x2000; MUL 0x8000*0x8000 -> SAT_EN 0x7FFF, else 0x8000.
//  acc_clr+MAC 0x4000*0x4000, then 3x MAC same -> results 0x2000,0x4000,0x6000,0x8000-or-0x7FFF(SAT).
//  out_ready=0 for 5 cycles with 4 ops streamed -> in_ready drops after 2 accepted; all 4 emerge
//   in order, unchanged, none lost or repeated.
//  sel=0011 -> err=1, result 0, zflag=1; sel=1100 a=b=0x1234 -> result 1; a!=b -> result 0, zflag=1.
//  rst_n low while 2 ops in flight -> out_valid=0 immediately (async), acc=0, no output after release.

Source files
------------

// File: rtl/audio_alu_pkg.sv
// Opcode encodings, opcode enum and legality helper for the pipelined audio ALU.
package audio_alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [3:0] OP_MAC  = 4'b0101;
    localparam logic [3:0] OP_AND  = 4'b0111;
    localparam logic [3:0] OP_OR   = 4'b1000;
    localparam logic [3:0] OP_XOR  = 4'b1001;
    localparam logic [3:0] OP_XNOR = 4'b1010;
    localparam logic [3:0] OP_EQ   = 4'b1100;
    localparam logic [3:0] OP_NOP  = 4'b1101;

    typedef enum logic [3:0] {
        ALU_ADD  = OP_ADD,
        ALU_SUB  = OP_SUB,
        ALU_MUL  = OP_MUL,
        ALU_MAC  = OP_MAC,
        ALU_AND  = OP_AND,
        ALU_OR   = OP_OR,
        ALU_XOR  = OP_XOR,
        ALU_XNOR = OP_XNOR,
        ALU_EQ   = OP_EQ,
        ALU_NOP  = OP_NOP
    } alu_op_e;

    function automatic logic is_legal_op(input logic [3:0] sel);
        case (sel)
            OP_ADD, OP_SUB, OP_MUL, OP_MAC, OP_AND,
            OP_OR, OP_XOR, OP_XNOR, OP_EQ, OP_NOP: return 1'b1;
            default:                               return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/audio_alu_sat.sv
// Signed narrowing IN_W -> WIDTH. With ALU_SAT_EN defined the value is clamped
// to the WIDTH-bit signed range; otherwise the low WIDTH bits are kept (wrap).
module audio_alu_sat #(
    parameter int IN_W  = 32,
    parameter int WIDTH = 16
) (
    input  logic signed [IN_W-1:0] din,
    output logic [WIDTH-1:0]       dout
);

`ifdef ALU_SAT_EN
    localparam logic signed [IN_W-1:0] MAXV = {{(IN_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [IN_W-1:0] MINV = {{(IN_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    always_comb begin
        if (din > MAXV)
            dout = MAXV[WIDTH-1:0];
        else if (din < MINV)
            dout = MINV[WIDTH-1:0];
        else
            dout = din[WIDTH-1:0];
    end
`else
    logic unused_hi;
    assign unused_hi = ^din[IN_W-1:WIDTH];
    assign dout      = din[WIDTH-1:0];
`endif

endmodule

// File: rtl/audio_alu_pipe.sv
// Two-stage valid/ready audio ALU with MAC accumulator (Q-format signed operands).
// Optional output clamping of ADD/SUB/MUL/MAC via the ALU_SAT_EN macro.
import audio_alu_pkg::*;

module audio_alu_pipe #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 15,
    parameter int ACC_W = 40
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       sel,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zflag,
    output logic             err
);

    localparam int PW = 2 * WIDTH;

    logic                    s1_v;
    logic signed [WIDTH-1:0] s1_a;
    logic signed [WIDTH-1:0] s1_b;
    logic [3:0]              s1_op;
    logic                    s1_clr;
    logic signed [ACC_W-1:0] acc;

    logic                    s1_adv;
    logic                    accept;
    logic signed [WIDTH:0]   sum;
    logic signed [WIDTH:0]   diff;
    logic signed [PW-1:0]    prod;
    logic signed [PW-1:0]    prod_sh;
    logic signed [ACC_W-1:0] prod_acc;
    logic signed [ACC_W-1:0] acc_next;
    logic signed [PW-1:0]    arith_wide;
    logic [WIDTH-1:0]        arith_n;
    logic [WIDTH-1:0]        mac_n;
    logic [WIDTH-1:0]        res_d;

    // S1 may move on whenever S2 is empty or draining; no bubbles are inserted.
    assign s1_adv   = s1_v & (~out_valid | out_ready);
    assign in_ready = ~s1_v | ~out_valid | out_ready;
    assign accept   = in_valid & in_ready;

    assign sum      = (WIDTH+1)'(s1_a) + (WIDTH+1)'(s1_b);
    assign diff     = (WIDTH+1)'(s1_a) - (WIDTH+1)'(s1_b);
    assign prod     = PW'(s1_a) * PW'(s1_b);
    assign prod_sh  = prod >>> FRAC;
    assign prod_acc = ACC_W'(prod_sh);

    always_comb begin
        acc_next = acc;
        if (s1_op == OP_MAC)
            acc_next = (s1_clr ? '0 : acc) + prod_acc;
        else if (s1_clr)
            acc_next = '0;
    end

    always_comb begin
        arith_wide = '0;
        case (s1_op)
            OP_ADD:  arith_wide = PW'(sum);
            OP_SUB:  arith_wide = PW'(diff);
            OP_MUL:  arith_wide = prod_sh;
            default: arith_wide = '0;
        endcase
    end

    audio_alu_sat #(.IN_W(PW), .WIDTH(WIDTH)) u_sat_arith (
        .din  (arith_wide),
        .dout (arith_n)
    );

    audio_alu_sat #(.IN_W(ACC_W), .WIDTH(WIDTH)) u_sat_mac (
        .din  (acc_next),
        .dout (mac_n)
    );

    always_comb begin
        res_d = '0;
        case (alu_op_e'(s1_op))
            ALU_ADD, ALU_SUB, ALU_MUL: res_d = arith_n;
            ALU_MAC:                   res_d = mac_n;
            ALU_AND:                   res_d = s1_a & s1_b;
            ALU_OR:                    res_d = s1_a | s1_b;
            ALU_XOR:                   res_d = s1_a ^ s1_b;
            ALU_XNOR:                  res_d = ~(s1_a ^ s1_b);
            ALU_EQ:                    res_d = WIDTH'(s1_a == s1_b);
            default:                   res_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v      <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_op     <= OP_NOP;
            s1_clr    <= 1'b0;
            out_valid <= 1'b0;
            result    <= '0;
            zflag     <= 1'b1;
            err       <= 1'b0;
            acc       <= '0;
        end else begin
            s1_v      <= accept | (s1_v & ~s1_adv);
            out_valid <= s1_adv | (out_valid & ~out_ready);
            if (accept) begin
                s1_a   <= a;
                s1_b   <= b;
                s1_op  <= sel;
                s1_clr <= acc_clr;
            end
            if (s1_adv) begin
                acc    <= acc_next;
                result <= res_d;
                zflag  <= (res_d == '0);
                err    <= ~is_legal_op(s1_op);
            end
        end
    end

endmodule

// File: tb/tb_audio_alu_pipe.sv
// Scoreboard bench for audio_alu_pipe: directed vectors push expected results,
// a negedge monitor pops and compares whenever an output transfer happens.
module tb_audio_alu_pipe;

`ifdef ALU_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  sel;
    logic        acc_clr;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        zflag;
    logic        err;

    typedef struct {
        logic [15:0] res;
        logic        z;
        logic        e;
        string       name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    logic        prev_stall = 1'b0;
    logic [15:0] prev_res;
    logic        prev_z;
    logic        prev_e;

    always #5 clk = ~clk;

    audio_alu_pipe #(.WIDTH(16), .FRAC(15), .ACC_W(40)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sel       (sel),
        .acc_clr   (acc_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zflag     (zflag),
        .err       (err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    // Monitor: scoreboard pop on every output transfer, plus hold check while stalled.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_hold_valid", 32'(out_valid), 32'd1);
                chk("stall_hold_result", 32'(result), 32'(prev_res));
                chk("stall_hold_flags", {30'd0, zflag, err}, {30'd0, prev_z, prev_e});
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got result 0x%0h with empty scoreboard", result);
                end else begin
                    mon_e = sb.pop_front();
                    chk({mon_e.name, "_result"}, 32'(result), 32'(mon_e.res));
                    chk({mon_e.name, "_flags"}, {30'd0, zflag, err}, {30'd0, mon_e.z, mon_e.e});
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_res   = result;
            prev_z     = zflag;
            prev_e     = err;
        end
    end

    task automatic send(input logic [15:0] ta, input logic [15:0] tbv, input logic [3:0] ts,
                        input logic tc, input logic [15:0] er, input logic ee, input string nm);
        int n;
        exp_t e;
        @(negedge clk);
        a        = ta;
        b        = tbv;
        sel      = ts;
        acc_clr  = tc;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL %s_accept_timeout: in_ready stayed 0 for %0d cycles", nm, n);
        end else begin
            e.res  = er;
            e.z    = (er == 16'h0000);
            e.e    = ee;
            e.name = nm;
            sb.push_back(e);
            @(posedge clk);
        end
        #1;
        in_valid = 1'b0;
        acc_clr  = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d results still pending", sb.size());
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        sel       = '0;
        acc_clr   = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_zflag", 32'(zflag), 32'd1);
        chk("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1 chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Latency: one edge into S1, the next into S2.
        @(negedge clk);
        a = 16'h7FFF; b = 16'h0001; sel = 4'b0000; in_valid = 1'b1;
        chk("lat_in_ready", 32'(in_ready), 32'd1);
        sb.push_back('{SAT ? 16'h7FFF : 16'h8000, 1'b0, 1'b0, "add_ovf"});
        @(negedge clk);
        in_valid = 1'b0;
        chk("lat_cycle1_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("lat_cycle2_valid", 32'(out_valid), 32'd1);
        drain();

        send(16'h0005, 16'hFFFB, 4'b0000, 1'b0, 16'h0000, 1'b0, "add_zero");
        send(16'h8000, 16'h0001, 4'b0001, 1'b0, SAT ? 16'h8000 : 16'h7FFF, 1'b0, "sub_ovf");
        send(16'h4000, 16'h4000, 4'b0010, 1'b0, 16'h2000, 1'b0, "mul_half");
        send(16'h8000, 16'h8000, 4'b0010, 1'b0, SAT ? 16'h7FFF : 16'h8000, 1'b0, "mul_neg1");
        send(16'hF0F0, 16'h0FF0, 4'b0111, 1'b0, 16'h00F0, 1'b0, "and");
        send(16'hF0F0, 16'h0FF0, 4'b1000, 1'b0, 16'hFFF0, 1'b0, "or");
        send(16'hF0F0, 16'h0FF0, 4'b1001, 1'b0, 16'hFF00, 1'b0, "xor");
        send(16'hF0F0, 16'h0FF0, 4'b1010, 1'b0, 16'h00FF, 1'b0, "xnor");
        send(16'h1234, 16'h1234, 4'b1100, 1'b0, 16'h0001, 1'b0, "eq_same");
        send(16'h1234, 16'h1235, 4'b1100, 1'b0, 16'h0000, 1'b0, "eq_diff");
        send(16'h1234, 16'h5678, 4'b1101, 1'b0, 16'h0000, 1'b0, "nop");
        send(16'h1234, 16'h5678, 4'b0011, 1'b0, 16'h0000, 1'b1, "illegal_0011");
        send(16'h1234, 16'h5678, 4'b1111, 1'b0, 16'h0000, 1'b1, "illegal_1111");
        drain();

        send(16'h4000, 16'h4000, 4'b0101, 1'b1, 16'h2000, 1'b0, "mac1_clr");
        send(16'h4000, 16'h4000, 4'b0101, 1'b0, 16'h4000, 1'b0, "mac2");
        send(16'h4000, 16'h4000, 4'b0101, 1'b0, 16'h6000, 1'b0, "mac3");
        send(16'h4000, 16'h4000, 4'b0101, 1'b0, SAT ? 16'h7FFF : 16'h8000, 1'b0, "mac4");
        // acc_clr with a non-MAC op zeroes acc; the next MAC starts from zero.
        send(16'h0001, 16'h0001, 4'b0111, 1'b1, 16'h0001, 1'b0, "and_clr");
        send(16'h4000, 16'h4000, 4'b0101, 1'b0, 16'h2000, 1'b0, "mac_after_clr");
        drain();

        // Backpressure: two ops fill the pipe, then in_ready must drop.
        @(negedge clk);
        out_ready = 1'b0;
        send(16'h1111, 16'h0001, 4'b0000, 1'b0, 16'h1112, 1'b0, "stall_op1");
        send(16'h2222, 16'h0002, 4'b0000, 1'b0, 16'h2224, 1'b0, "stall_op2");
        @(negedge clk);
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        fork
            begin
                send(16'h3333, 16'h0003, 4'b0000, 1'b0, 16'h3336, 1'b0, "stall_op3");
                send(16'h4444, 16'h0004, 4'b0001, 1'b0, 16'h4440, 1'b0, "stall_op4");
            end
            begin
                repeat (3) @(posedge clk);
                #2 out_ready = 1'b1;
            end
        join
        drain();

        // Asynchronous reset with two MACs in flight.
        send(16'h4000, 16'h4000, 4'b0101, 1'b1, 16'h2000, 1'b0, "rst_mac1");
        send(16'h4000, 16'h4000, 4'b0101, 1'b0, 16'h4000, 1'b0, "rst_mac2");
        @(negedge clk);
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_result", 32'(result), 32'd0);
        chk("async_rst_flags", {30'd0, zflag, err}, {30'd0, 1'b1, 1'b0});
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 chk("rst_release_in_ready", 32'(in_ready), 32'd1);
        repeat (4) @(negedge clk);
        chk("rst_no_output", 32'(out_valid), 32'd0);
        send(16'h4000, 16'h4000, 4'b0101, 1'b0, 16'h2000, 1'b0, "mac_after_rst");
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
